mem_bus_ctrl: RTL and testbench



---
 rtl/mem_bus_ctrl_if.sv | 35 +++
 rtl/mem_bus_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Signal bundle for mem_bus_ctrl: fetch/data request handshakes plus the multiplexed memory bus.
// master is the controller's view; slave is the view of the requesters and the memory.
interface mem_bus_ctrl_if #(
   parameter int DW = 16
);
   logic          FReq;
   logic [DW-1:0] FAddr;
   logic          FAck;
   logic          DReq;
   logic          DWrite;
   logic [DW-1:0] DAddr;
   logic [DW-1:0] DWData;
   logic          DAck;
   logic [DW-1:0] RData;
   logic          Err;
   logic          Busy;
   logic [DW-1:0] DataOut;
   logic [DW-1:0] DataIn;
   logic          Enb;
   logic          Ale;
   logic          nMe;
   logic          nOe;
   logic          RnW;
   logic          nWait;

   modport master (
      input  FReq, FAddr, DReq, DWrite, DAddr, DWData, DataIn, nWait,
      output FAck, DAck, RData, Err, Busy, DataOut, Enb, Ale, nMe, nOe, RnW
   );

   modport slave (
      output FReq, FAddr, DReq, DWrite, DAddr, DWData, DataIn, nWait,
      input  FAck, DAck, RData, Err, Busy, DataOut, Enb, Ale, nMe, nOe, RnW
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Multiplexed memory bus sequencer shared round-robin between instruction fetch and data access.
// Fixed ADDR/DATA/END cycle, nWait stretching with timeout abort, one-cycle Ack with read data.
module mem_bus_ctrl #(
   parameter int DW       = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic           Clock,
   input  logic           nReset,
   mem_bus_ctrl_if.master bus
);
   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);
   localparam logic [CW-1:0] WAIT_ONE   = CW'(32'd1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      END  = 2'd3
   } state_t;

   state_t        state_r;
   state_t        stateNext_s;
   logic          anyReq_s;
   logic          grantData_s;
   logic          timeout_s;
   logic          gntData_r;
   logic          lastGntData_r;
   logic          opWrite_r;
   logic [DW-1:0] wData_r;
   logic [CW-1:0] waitCnt_r;

   logic [DW-1:0] dataOut_r, dataOutNext_s;
   logic [DW-1:0] rData_r, rDataNext_s;
   logic          enb_r, enbNext_s;
   logic          ale_r, aleNext_s;
   logic          nMe_r, nMeNext_s;
   logic          nOe_r, nOeNext_s;
   logic          rnW_r, rnWNext_s;
   logic          fAck_r, fAckNext_s;
   logic          dAck_r, dAckNext_s;
   logic          err_r, errNext_s;
   logic          busy_r, busyNext_s;

   // On a tie the requester not granted last time wins
   assign anyReq_s    = bus.FReq | bus.DReq;
   assign grantData_s = bus.DReq & (~bus.FReq | ~lastGntData_r);

   assign bus.DataOut = dataOut_r;
   assign bus.RData   = rData_r;
   assign bus.Enb     = enb_r;
   assign bus.Ale     = ale_r;
   assign bus.nMe     = nMe_r;
   assign bus.nOe     = nOe_r;
   assign bus.RnW     = rnW_r;
   assign bus.FAck    = fAck_r;
   assign bus.DAck    = dAck_r;
   assign bus.Err     = err_r;
   assign bus.Busy    = busy_r;

   // State register
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_r <= IDLE;
      end else begin
         state_r <= stateNext_s;
      end
   end

   // Next-state decode, including the wait timeout
   always_comb begin
      stateNext_s = state_r;
      timeout_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (anyReq_s) begin
               stateNext_s = ADDR;
            end else begin
               stateNext_s = IDLE;
            end
         end
         ADDR: stateNext_s = DATA;
         DATA: begin
            if (bus.nWait) begin
               stateNext_s = END;
            end else if (waitCnt_r == WAIT_LIMIT) begin
               stateNext_s = END;
               timeout_s   = 1'b1;
            end else begin
               stateNext_s = DATA;
            end
         end
         END:     stateNext_s = IDLE;
         default: stateNext_s = IDLE;
      endcase
   end

   // Moore output decode for the state being entered; DataOut/RnW/RData hold unless updated
   always_comb begin
      dataOutNext_s = dataOut_r;
      rDataNext_s   = rData_r;
      rnWNext_s     = rnW_r;
      enbNext_s     = 1'b0;
      aleNext_s     = 1'b0;
      nMeNext_s     = 1'b1;
      nOeNext_s     = 1'b1;
      fAckNext_s    = 1'b0;
      dAckNext_s    = 1'b0;
      errNext_s     = 1'b0;
      busyNext_s    = (stateNext_s != IDLE);
      case (stateNext_s)
         ADDR: begin
            // Request is latched on this same edge, so take it straight from the winner
            dataOutNext_s = grantData_s ? bus.DAddr : bus.FAddr;
            rnWNext_s     = ~(grantData_s & bus.DWrite);
            enbNext_s     = 1'b1;
            aleNext_s     = 1'b1;
         end
         DATA: begin
            nMeNext_s = 1'b0;
            if (opWrite_r) begin
               enbNext_s     = 1'b1;
               dataOutNext_s = wData_r;
            end else begin
               nOeNext_s = 1'b0;
            end
         end
         END: begin
            fAckNext_s = ~gntData_r;
            dAckNext_s = gntData_r;
            errNext_s  = timeout_s;
            if (!opWrite_r && !timeout_s) begin
               rDataNext_s = bus.DataIn;
            end else begin
               rDataNext_s = rData_r;
            end
         end
         IDLE:    busyNext_s = 1'b0;
         default: busyNext_s = 1'b0;
      endcase
   end

   // Registered bus and handshake outputs
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         dataOut_r <= {DW{1'b0}};
         rData_r   <= {DW{1'b0}};
         enb_r     <= 1'b0;
         ale_r     <= 1'b0;
         nMe_r     <= 1'b1;
         nOe_r     <= 1'b1;
         rnW_r     <= 1'b1;
         fAck_r    <= 1'b0;
         dAck_r    <= 1'b0;
         err_r     <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         dataOut_r <= dataOutNext_s;
         rData_r   <= rDataNext_s;
         enb_r     <= enbNext_s;
         ale_r     <= aleNext_s;
         nMe_r     <= nMeNext_s;
         nOe_r     <= nOeNext_s;
         rnW_r     <= rnWNext_s;
         fAck_r    <= fAckNext_s;
         dAck_r    <= dAckNext_s;
         err_r     <= errNext_s;
         busy_r    <= busyNext_s;
      end
   end

   // Latch the winning request on grant and count nWait-low edges in DATA
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         gntData_r     <= 1'b0;
         lastGntData_r <= 1'b1;
         opWrite_r     <= 1'b0;
         wData_r       <= {DW{1'b0}};
         waitCnt_r     <= {CW{1'b0}};
      end else begin
         if (state_r == IDLE && anyReq_s) begin
            gntData_r     <= grantData_s;
            lastGntData_r <= grantData_s;
            opWrite_r     <= grantData_s & bus.DWrite;
            wData_r       <= bus.DWData;
         end
         if (stateNext_s == ADDR) begin
            waitCnt_r <= {CW{1'b0}};
         end else if (state_r == DATA && stateNext_s == DATA) begin
            waitCnt_r <= waitCnt_r + WAIT_ONE;
         end
      end
   end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed scenarios plus randomized transactions
// checked against a cycle-count / data model derived from the bus protocol rules.
module tb_mem_bus_ctrl;
   localparam int DW       = 16;
   localparam int MAX_WAIT = 15;
   localparam int TMAX     = 40;

   logic Clock  = 1'b0;
   logic nReset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mem_bus_ctrl_if #(.DW(DW)) busIf ();

   mem_bus_ctrl #(.DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .Clock  (Clock),
      .nReset (nReset),
      .bus    (busIf)
   );

   always #5 Clock = ~Clock;

   // Per-cycle trace of one transaction; strobes packed as {Ale, nMe, nOe, Enb, RnW}
   logic [4:0]    trStb  [TMAX];
   logic [DW-1:0] trDout [TMAX];
   logic [1:0]    trAck  [TMAX];
   logic          trErr  [TMAX];
   logic          trBusy [TMAX];
   int            ackCyc;
   logic [1:0]    ackWho;
   logic          ackErr;
   logic [DW-1:0] ackRData;
   logic          bothAck;
   logic [DW-1:0] expRData;

   task automatic apply_reset();
      nReset       = 1'b0;
      busIf.FReq   = 1'b0;
      busIf.DReq   = 1'b0;
      busIf.DWrite = 1'b0;
      busIf.FAddr  = 16'h0000;
      busIf.DAddr  = 16'h0000;
      busIf.DWData = 16'h0000;
      busIf.DataIn = 16'h0000;
      busIf.nWait  = 1'b1;
      @(posedge Clock);
      @(posedge Clock);
      @(negedge Clock);
      nReset   = 1'b1;
      expRData = 16'h0000;
   endtask

   // Issue one request at cycle 0 (starting from a negedge in IDLE) and trace until one cycle past the Ack.
   // nWait is low for w DATA edges; DataIn carries rdVal on the edge that should complete the read.
   task automatic run_txn(input bit isData, input bit isWrite, input logic [DW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdVal, input int w);
      int dataEnd;
      dataEnd  = 2 + ((w > MAX_WAIT) ? MAX_WAIT : w);
      ackCyc   = -1;
      ackWho   = 2'b00;
      ackErr   = 1'b0;
      ackRData = 16'h0000;
      bothAck  = 1'b0;
      for (int k = 0; k < TMAX; k++) begin
         trStb[k]  = {busIf.Ale, busIf.nMe, busIf.nOe, busIf.Enb, busIf.RnW};
         trDout[k] = busIf.DataOut;
         trAck[k]  = {busIf.FAck, busIf.DAck};
         trErr[k]  = busIf.Err;
         trBusy[k] = busIf.Busy;
         if (busIf.FAck && busIf.DAck) bothAck = 1'b1;
         if (ackCyc >= 0) break;
         if (busIf.FAck || busIf.DAck) begin
            ackCyc     = k;
            ackWho     = {busIf.FAck, busIf.DAck};
            ackErr     = busIf.Err;
            ackRData   = busIf.RData;
            busIf.FReq = 1'b0;
            busIf.DReq = 1'b0;
         end else if (k == 0) begin
            busIf.FReq   = !isData;
            busIf.DReq   = isData;
            busIf.FAddr  = isData ? DW'($urandom) : addr;
            busIf.DAddr  = isData ? addr : DW'($urandom);
            busIf.DWrite = isData ? isWrite : 1'($urandom_range(0, 1));
            busIf.DWData = wdata;
         end else begin
            // Request fields may change after grant and must not matter
            busIf.FAddr  = DW'($urandom);
            busIf.DAddr  = DW'($urandom);
            busIf.DWData = DW'($urandom);
            busIf.DWrite = 1'($urandom_range(0, 1));
         end
         if (k >= 2 && k < 2 + w)        busIf.nWait = 1'b0;
         else if (k >= 2 && k <= dataEnd) busIf.nWait = 1'b1;
         else                             busIf.nWait = 1'($urandom_range(0, 1));
         busIf.DataIn = (k == 2 + w) ? rdVal : DW'($urandom);
         @(posedge Clock);
         @(negedge Clock);
      end
      busIf.FReq = 1'b0;
      busIf.DReq = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if ({busIf.Ale, busIf.nMe, busIf.nOe, busIf.Enb, busIf.RnW} !== 5'b01101) begin
         errors++; $display("FAIL reset_strobes: got %b, expected 01101", {busIf.Ale, busIf.nMe, busIf.nOe, busIf.Enb, busIf.RnW}); end
      checks++; if (busIf.DataOut !== 16'h0000) begin
         errors++; $display("FAIL reset_dataout: got %h, expected 0000", busIf.DataOut); end
      checks++; if ({busIf.FAck, busIf.DAck} !== 2'b00) begin
         errors++; $display("FAIL reset_acks: got %b, expected 00", {busIf.FAck, busIf.DAck}); end
      checks++; if (busIf.RData !== 16'h0000) begin
         errors++; $display("FAIL reset_rdata: got %h, expected 0000", busIf.RData); end
      checks++; if ({busIf.Err, busIf.Busy} !== 2'b00) begin
         errors++; $display("FAIL reset_err_busy: got %b, expected 00", {busIf.Err, busIf.Busy}); end
   endtask

   task automatic test_fetch_read();
      run_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 16'hA5C3, 0);
      expRData = 16'hA5C3;
      checks++; if (trStb[1] !== 5'b11111 || trDout[1] !== 16'h0040) begin
         errors++; $display("FAIL fetch_addr_phase: got stb=%b dout=%h, expected stb=11111 dout=0040", trStb[1], trDout[1]); end
      checks++; if (trStb[2] !== 5'b00001) begin
         errors++; $display("FAIL fetch_data_phase: got %b, expected 00001", trStb[2]); end
      checks++; if (ackCyc !== 3 || ackWho !== 2'b10) begin
         errors++; $display("FAIL fetch_ack: got cycle=%0d who=%b, expected cycle=3 who=10", ackCyc, ackWho); end
      checks++; if (ackRData !== expRData || ackErr !== 1'b0) begin
         errors++; $display("FAIL fetch_rdata: got %h err=%b, expected %h err=0", ackRData, ackErr, expRData); end
      checks++; if (trStb[3] !== 5'b01101) begin
         errors++; $display("FAIL fetch_end_strobes: got %b, expected 01101", trStb[3]); end
      checks++; if (trAck[4] !== 2'b00 || trBusy[4] !== 1'b0 || trBusy[2] !== 1'b1) begin
         errors++; $display("FAIL fetch_ack_pulse_busy: got ack=%b busy4=%b busy2=%b, expected 00 0 1", trAck[4], trBusy[4], trBusy[2]); end
   endtask

   task automatic test_data_write();
      run_txn(1'b1, 1'b1, 16'h1234, 16'hBEEF, DW'($urandom), 0);
      checks++; if (trStb[1] !== 5'b11110 || trDout[1] !== 16'h1234) begin
         errors++; $display("FAIL write_addr_phase: got stb=%b dout=%h, expected stb=11110 dout=1234", trStb[1], trDout[1]); end
      checks++; if (trStb[2] !== 5'b00110 || trDout[2] !== 16'hBEEF) begin
         errors++; $display("FAIL write_data_phase: got stb=%b dout=%h, expected stb=00110 dout=beef", trStb[2], trDout[2]); end
      checks++; if (ackCyc !== 3 || ackWho !== 2'b01 || ackErr !== 1'b0) begin
         errors++; $display("FAIL write_ack: got cycle=%0d who=%b err=%b, expected 3 01 0", ackCyc, ackWho, ackErr); end
      checks++; if (trStb[3] !== 5'b01100 || ackRData !== expRData) begin
         errors++; $display("FAIL write_end: got stb=%b rdata=%h, expected stb=01100 rdata=%h", trStb[3], ackRData, expRData); end
   endtask

   task automatic test_wait_read();
      logic [DW-1:0] rd;
      rd = DW'($urandom);
      run_txn(1'b1, 1'b0, DW'($urandom), DW'($urandom), rd, 3);
      expRData = rd;
      checks++; if (ackCyc !== 6 || ackWho !== 2'b01) begin
         errors++; $display("FAIL wait_ack: got cycle=%0d who=%b, expected cycle=6 who=01", ackCyc, ackWho); end
      checks++; if (ackRData !== expRData || ackErr !== 1'b0) begin
         errors++; $display("FAIL wait_rdata: got %h err=%b, expected %h err=0", ackRData, ackErr, expRData); end
      for (int c = 2; c <= 5; c++) begin
         checks++; if (trStb[c] !== 5'b00001) begin
            errors++; $display("FAIL wait_data_cycle%0d: got %b, expected 00001", c, trStb[c]); end
      end
   endtask

   task automatic test_timeout();
      logic [DW-1:0] rd;
      run_txn(1'b0, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), MAX_WAIT + 5);
      checks++; if (ackCyc !== 3 + MAX_WAIT || ackErr !== 1'b1) begin
         errors++; $display("FAIL timeout_ack: got cycle=%0d err=%b, expected cycle=%0d err=1", ackCyc, ackErr, 3 + MAX_WAIT); end
      checks++; if (ackRData !== expRData) begin
         errors++; $display("FAIL timeout_rdata: got %h, expected %h", ackRData, expRData); end
      checks++; if (trStb[3 + MAX_WAIT] !== 5'b01101 || trErr[4 + MAX_WAIT] !== 1'b0) begin
         errors++; $display("FAIL timeout_end: got stb=%b err_after=%b, expected 01101 0", trStb[3 + MAX_WAIT], trErr[4 + MAX_WAIT]); end
      // Exactly MAX_WAIT wait edges still completes cleanly
      rd = DW'($urandom);
      run_txn(1'b1, 1'b0, DW'($urandom), DW'($urandom), rd, MAX_WAIT);
      expRData = rd;
      checks++; if (ackCyc !== 3 + MAX_WAIT || ackErr !== 1'b0 || ackRData !== expRData) begin
         errors++; $display("FAIL maxwait_edge: got cycle=%0d err=%b rdata=%h, expected %0d 0 %h", ackCyc, ackErr, ackRData, 3 + MAX_WAIT, expRData); end
   endtask

   task automatic test_random();
      bit isData, isWrite, expErr;
      int w, expCyc;
      logic [DW-1:0] addr, wdata, rd;
      for (int i = 0; i < 40; i++) begin
         isData  = 1'($urandom_range(0, 1));
         isWrite = isData & 1'($urandom_range(0, 1));
         addr    = DW'($urandom);
         wdata   = DW'($urandom);
         rd      = DW'($urandom);
         w       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MAX_WAIT - 1, MAX_WAIT + 2)) : int'($urandom_range(0, 4));
         expErr  = (w > MAX_WAIT);
         expCyc  = 3 + (expErr ? MAX_WAIT : w);
         if (!isWrite && !expErr) expRData = rd;
         run_txn(isData, isWrite, addr, wdata, rd, w);
         checks++; if (ackCyc !== expCyc || ackErr !== expErr || ackWho !== (isData ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL rand%0d_ack: got cycle=%0d err=%b who=%b, expected %0d %b %b", i, ackCyc, ackErr, ackWho, expCyc, expErr, isData ? 2'b01 : 2'b10); end
         checks++; if (ackRData !== expRData) begin
            errors++; $display("FAIL rand%0d_rdata: got %h, expected %h", i, ackRData, expRData); end
         checks++; if (trDout[1] !== addr || trStb[1] !== {4'b1111, !isWrite}) begin
            errors++; $display("FAIL rand%0d_addr: got dout=%h stb=%b, expected %h %b", i, trDout[1], trStb[1], addr, {4'b1111, !isWrite}); end
         if (isWrite) begin
            checks++; if (trDout[2] !== wdata) begin
               errors++; $display("FAIL rand%0d_wdata: got %h, expected %h", i, trDout[2], wdata); end
         end
         checks++; if (bothAck !== 1'b0) begin
            errors++; $display("FAIL rand%0d_dual_ack: got %b, expected 0", i, bothAck); end
      end
   endtask

   task automatic test_back_to_back();
      int order [6];
      int n, simul, grants;
      logic fDrop, dDrop;
      logic [DW-1:0] fA, dA;
      apply_reset();
      fA = DW'($urandom);
      dA = DW'($urandom);
      for (int i = 0; i < 6; i++) order[i] = -1;
      busIf.FAddr = fA; busIf.DAddr = dA; busIf.DWrite = 1'b0;
      busIf.FReq = 1'b1; busIf.DReq = 1'b1;
      n = 0; simul = 0; grants = 0; fDrop = 1'b0; dDrop = 1'b0;
      for (int k = 0; k < 400 && n < 6; k++) begin
         @(negedge Clock);
         if (busIf.FAck && busIf.DAck) simul++;
         if (busIf.Ale) begin
            // Grants alternate fetch, data, fetch, ... from reset
            checks++; if (busIf.DataOut !== ((grants % 2 == 0) ? fA : dA)) begin
               errors++; $display("FAIL b2b_grant%0d_addr: got %h, expected %h", grants, busIf.DataOut, (grants % 2 == 0) ? fA : dA); end
            grants++;
         end
         if (fDrop) begin busIf.FReq = 1'b1; fDrop = 1'b0; end
         if (dDrop) begin busIf.DReq = 1'b1; dDrop = 1'b0; end
         if (busIf.FAck) begin
            if (n < 6) order[n] = 0;
            n++; busIf.FReq = 1'b0; fDrop = 1'b1;
         end
         if (busIf.DAck) begin
            if (n < 6) order[n] = 1;
            n++; busIf.DReq = 1'b0; dDrop = 1'b1;
         end
         busIf.nWait  = ($urandom_range(0, 3) != 0);
         busIf.DataIn = DW'($urandom);
      end
      busIf.FReq = 1'b0;
      busIf.DReq = 1'b0;
      checks++; if (n !== 6) begin
         errors++; $display("FAIL b2b_ack_count: got %0d, expected 6", n); end
      for (int i = 0; i < 6; i++) begin
         checks++; if (order[i] !== i % 2) begin
            errors++; $display("FAIL b2b_order%0d: got %0d, expected %0d", i, order[i], i % 2); end
      end
      checks++; if (simul !== 0) begin
         errors++; $display("FAIL b2b_simultaneous_acks: got %0d, expected 0", simul); end
   endtask

   task automatic test_reset_mid();
      int acks;
      logic [DW-1:0] rd;
      apply_reset();
      busIf.DReq = 1'b1; busIf.DWrite = 1'b0; busIf.DAddr = DW'($urandom); busIf.nWait = 1'b0;
      @(posedge Clock);
      @(posedge Clock);
      @(negedge Clock);
      checks++; if ({busIf.nMe, busIf.nOe, busIf.Enb} !== 3'b000) begin
         errors++; $display("FAIL rstmid_in_data: got %b, expected 000", {busIf.nMe, busIf.nOe, busIf.Enb}); end
      #2 nReset = 1'b0;
      #1;
      checks++; if ({busIf.nMe, busIf.nOe, busIf.Enb, busIf.Ale, busIf.Busy} !== 5'b11000) begin
         errors++; $display("FAIL rstmid_async: got %b, expected 11000", {busIf.nMe, busIf.nOe, busIf.Enb, busIf.Ale, busIf.Busy}); end
      busIf.DReq = 1'b0;
      @(posedge Clock);
      @(negedge Clock);
      nReset = 1'b1;
      expRData = 16'h0000;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clock);
         if (busIf.FAck || busIf.DAck) acks++;
         busIf.nWait = 1'b1;
      end
      checks++; if (acks !== 0) begin
         errors++; $display("FAIL rstmid_no_ack: got %0d, expected 0", acks); end
      rd = DW'($urandom);
      run_txn(1'b1, 1'b0, DW'($urandom), DW'($urandom), rd, 1);
      expRData = rd;
      checks++; if (ackCyc !== 4 || ackWho !== 2'b01 || ackErr !== 1'b0 || ackRData !== expRData) begin
         errors++; $display("FAIL rstmid_fresh: got cycle=%0d who=%b err=%b rdata=%h, expected 4 01 0 %h", ackCyc, ackWho, ackErr, ackRData, expRData); end
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_fetch_read();
      test_data_write();
      test_wait_read();
      test_timeout();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
